seq_detect_prog: RTL and testbench

//  Programmable serial sequence detector, Moore output: match pattern/length/overlap mode are loadable at run time.

---
 rtl/seq_detect_prog.sv | 156 +++++++++++++++
 tb/tb_seq_detect_prog.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/seq_detect_prog.sv
// seq_detect_prog
//   Programmable serial sequence detector with a Moore output. The pattern,
//   its length and the overlap mode can be reloaded at run time. One qualified
//   bit is consumed per clock. Each detected occurrence produces a registered
//   one-cycle dout pulse and bumps a saturating match counter.
// Ports
//   clk, rst        clock; asynchronous active-low reset
//   en              detector enable (low parks the FSM in S_IDLE and wipes history)
//   din, din_valid  serial bit and its qualifier
//   cfg_load        load cfg_pattern / cfg_len / cfg_overlap this cycle
//   cfg_pattern     pattern, bit [len-1] received first, bit [0] received last
//   cfg_len         pattern length, legal range 1..PAT_W
//   cfg_overlap     1 = matches may share bits
//   clr_count       synchronous clear of match_count (wins over an increment)
//   dout            match pulse, high only while in S_HIT
//   match_count     saturating count of matches
//   cfg_err         one-cycle pulse when cfg_load carries an illegal cfg_len
module seq_detect_prog #(
  parameter int                PAT_W   = 8,
  parameter int                LEN_W   = 4,
  parameter int                CNT_W   = 16,
  parameter logic [PAT_W-1:0]  RST_PAT = 8'b0000_1010,
  parameter logic [LEN_W-1:0]  RST_LEN = LEN_W'(4),
  parameter logic              RST_OVL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             din_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             clr_count,
  output logic             dout,
  output logic [CNT_W-1:0] match_count,
  output logic             cfg_err
);

  typedef enum logic [1:0] {S_IDLE, S_HUNT, S_HIT} state_e;

  state_e           state_q, state_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovl_q, ovl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [PAT_W-1:0] len_mask;
  logic [PAT_W-1:0] hist_new;
  logic [LEN_W:0]   fill_inc;
  logic             cfg_ok;
  logic             match;
  logic             inc;

  // Only the low len_q bits of history and pattern take part in the compare.
  always_comb begin
    for (int i = 0; i < PAT_W; i++)
      len_mask[i] = ({1'b0, len_q} > (LEN_W+1)'(i));
  end

  assign cfg_ok   = (cfg_len != '0) && ({1'b0, cfg_len} <= (LEN_W+1)'(PAT_W));
  assign hist_new = {hist_q[PAT_W-2:0], din};
  assign fill_inc = {1'b0, fill_q} + (LEN_W+1)'(1);
  // fill counts bits that may still contribute to a match, so a match
  // needs at least len of them including the bit arriving now.
  assign match    = (fill_inc >= {1'b0, len_q}) &&
                    ((hist_new & len_mask) == (pat_q & len_mask));

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    err_d   = 1'b0;
    inc     = 1'b0;

    // Config is validated regardless of en; a bad length leaves it untouched.
    if (cfg_load) begin
      if (cfg_ok) begin
        pat_d = cfg_pattern;
        len_d = cfg_len;
        ovl_d = cfg_overlap;
      end else begin
        err_d = 1'b1;
      end
    end

    if (!en) begin
      state_d = S_IDLE;
      hist_d  = '0;
      fill_d  = '0;
    end else if (cfg_load && cfg_ok) begin
      state_d = S_HUNT;
      hist_d  = '0;
      fill_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_HUNT;
        S_HUNT, S_HIT: begin
          // A rejected cfg_load still swallows the bit offered with it.
          if (din_valid && !cfg_load) begin
            hist_d = hist_new;
            fill_d = (fill_inc > (LEN_W+1)'(PAT_W)) ? LEN_W'(PAT_W) : fill_inc[LEN_W-1:0];
            if (match) begin
              state_d = S_HIT;
              inc     = 1'b1;
              if (!ovl_q) fill_d = '0;
            end else begin
              state_d = S_HUNT;
            end
          end else begin
            state_d = S_HUNT;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    cnt_d = cnt_q;
    if (clr_count)          cnt_d = '0;
    else if (inc && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= RST_PAT;
      len_q   <= RST_LEN;
      ovl_q   <= RST_OVL;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign dout        = (state_q == S_HIT);
  assign match_count = cnt_q;
  assign cfg_err     = err_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
module tb_seq_detect_prog;

  logic       clk = 1'b0;
  logic       rst, en, din, din_valid, cfg_load, cfg_overlap, clr_count;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       dout, cfg_err, dout2, cfg_err2;
  logic [15:0] match_count;
  logic [1:0]  match_count2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_detect_prog dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .din_valid(din_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .clr_count(clr_count),
    .dout(dout), .match_count(match_count), .cfg_err(cfg_err)
  );

  // Narrow-counter copy sharing all stimulus, used for saturation checks.
  seq_detect_prog #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .din(din), .din_valid(din_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .clr_count(clr_count),
    .dout(dout2), .match_count(match_count2), .cfg_err(cfg_err2)
  );

  // Drive one bit, clock it in, land 1 ns after the edge for sampling.
  task automatic step(input logic d, input logic v);
    din = d; din_valid = v;
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o, input logic clr);
    cfg_load = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o; clr_count = clr;
    step(1'b0, 1'b0);
    cfg_load = 1'b0; clr_count = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; en = 1'b0; din = 1'b0; din_valid = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; clr_count = 1'b0;
    #2;
    n_chk++; if (dout !== 1'b0) begin n_fail++; $display("FAIL reset_dout: got %0b want 0", dout); end
    n_chk++; if (match_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", match_count); end
    n_chk++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b want 0", cfg_err); end
    #10 rst = 1'b1;
    @(posedge clk); #1;
    en = 1'b1;
    step(1'b0, 1'b0);  // IDLE -> HUNT
  endtask

  task automatic test_default_nonoverlap;
    logic [5:0] bits = 6'b101010;  // bits[5] sent first
    logic [5:0] exp  = 6'b000100;
    for (int i = 5; i >= 0; i--) begin
      step(bits[i], 1'b1);
      n_chk++; if (dout !== exp[i]) begin n_fail++; $display("FAIL nonovl_dout bit%0d: got %0b want %0b", 5-i, dout, exp[i]); end
    end
    n_chk++; if (match_count !== 16'd1) begin n_fail++; $display("FAIL nonovl_count: got %0d want 1", match_count); end
  endtask

  task automatic test_overlap;
    logic [5:0] bits = 6'b101010;
    logic [5:0] exp  = 6'b000101;
    load(8'h0A, 4'd4, 1'b1, 1'b1);
    n_chk++; if (match_count !== 16'd0) begin n_fail++; $display("FAIL ovl_clr: got %0d want 0", match_count); end
    for (int i = 5; i >= 0; i--) begin
      step(bits[i], 1'b1);
      n_chk++; if (dout !== exp[i]) begin n_fail++; $display("FAIL ovl_dout bit%0d: got %0b want %0b", 5-i, dout, exp[i]); end
    end
    n_chk++; if (match_count !== 16'd2) begin n_fail++; $display("FAIL ovl_count: got %0d want 2", match_count); end
  endtask

  task automatic test_back_to_back;
    load(8'h01, 4'd1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1);
      n_chk++; if (dout !== 1'b1) begin n_fail++; $display("FAIL b2b_dout cyc%0d: got %0b want 1", i, dout); end
    end
    n_chk++; if (match_count !== 16'd7) begin n_fail++; $display("FAIL b2b_count: got %0d want 7", match_count); end
    step(1'b1, 1'b0);
    n_chk++; if (dout !== 1'b0) begin n_fail++; $display("FAIL b2b_gap_dout: got %0b want 0", dout); end
  endtask

  task automatic test_cfg_err;
    load(8'h0A, 4'd0, 1'b0, 1'b0);
    n_chk++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL err_len0: got %0b want 1", cfg_err); end
    step(1'b0, 1'b0);
    n_chk++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL err_pulse_width: got %0b want 0", cfg_err); end
    load(8'h0A, 4'd9, 1'b0, 1'b0);
    n_chk++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL err_len9: got %0b want 1", cfg_err); end
    step(1'b1, 1'b1);  // prior len=1 pattern '1' must still fire
    n_chk++; if (dout !== 1'b1) begin n_fail++; $display("FAIL err_keepcfg_hit: got %0b want 1", dout); end
    step(1'b0, 1'b1);
    n_chk++; if (dout !== 1'b0) begin n_fail++; $display("FAIL err_keepcfg_miss: got %0b want 0", dout); end
    n_chk++; if (match_count !== 16'd8) begin n_fail++; $display("FAIL err_count: got %0d want 8", match_count); end
  endtask

  task automatic test_valid_gaps;
    logic [6:0] d = 7'b1000010;  // d[6] first
    logic [6:0] v = 7'b1010011;
    logic [6:0] e = 7'b0000001;
    load(8'h0A, 4'd4, 1'b0, 1'b1);
    for (int i = 6; i >= 0; i--) begin
      step(d[i], v[i]);
      n_chk++; if (dout !== e[i]) begin n_fail++; $display("FAIL gap_dout cyc%0d: got %0b want %0b", 6-i, dout, e[i]); end
    end
    n_chk++; if (match_count !== 16'd1) begin n_fail++; $display("FAIL gap_count: got %0d want 1", match_count); end
  endtask

  task automatic test_en_drop;
    logic [3:0] bits = 4'b1010;
    step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1);
    en = 1'b0; step(1'b0, 1'b0);
    en = 1'b1; step(1'b0, 1'b1);  // IDLE -> HUNT, bit ignored
    step(1'b0, 1'b1);             // would complete 1010 if history survived
    n_chk++; if (dout !== 1'b0) begin n_fail++; $display("FAIL endrop_nomatch: got %0b want 0", dout); end
    for (int i = 3; i >= 0; i--) begin
      step(bits[i], 1'b1);
      n_chk++; if (dout !== (i == 0)) begin n_fail++; $display("FAIL endrop_dout bit%0d: got %0b want %0b", 3-i, dout, (i == 0)); end
    end
    n_chk++; if (match_count !== 16'd2) begin n_fail++; $display("FAIL endrop_count: got %0d want 2", match_count); end
  endtask

  task automatic test_async_reset;
    logic [3:0] bits = 4'b1010;
    load(8'h01, 4'd1, 1'b1, 1'b0);
    step(1'b1, 1'b1);
    n_chk++; if (dout !== 1'b1) begin n_fail++; $display("FAIL rst_pre_dout: got %0b want 1", dout); end
    rst = 1'b0; #2;
    n_chk++; if (dout !== 1'b0) begin n_fail++; $display("FAIL rst_async_dout: got %0b want 0", dout); end
    n_chk++; if (match_count !== 16'd0) begin n_fail++; $display("FAIL rst_async_count: got %0d want 0", match_count); end
    #2 rst = 1'b1; din_valid = 1'b0;
    @(posedge clk); #1;           // IDLE -> HUNT
    for (int i = 3; i >= 0; i--) begin
      step(bits[i], 1'b1);        // default 1010 config, not the len=1 one
      n_chk++; if (dout !== (i == 0)) begin n_fail++; $display("FAIL rst_cfg_dout bit%0d: got %0b want %0b", 3-i, dout, (i == 0)); end
    end
  endtask

  task automatic test_saturate;
    load(8'h01, 4'd1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    n_chk++; if (match_count2 !== 2'd3) begin n_fail++; $display("FAIL sat_count2: got %0d want 3", match_count2); end
    n_chk++; if (match_count !== 16'd5) begin n_fail++; $display("FAIL sat_count16: got %0d want 5", match_count); end
    clr_count = 1'b1; step(1'b1, 1'b1); clr_count = 1'b0;
    n_chk++; if (dout !== 1'b1) begin n_fail++; $display("FAIL clrwin_dout: got %0b want 1", dout); end
    n_chk++; if (match_count2 !== 2'd0) begin n_fail++; $display("FAIL clrwin_count2: got %0d want 0", match_count2); end
    n_chk++; if (match_count !== 16'd0) begin n_fail++; $display("FAIL clrwin_count16: got %0d want 0", match_count); end
    step(1'b1, 1'b1);
    n_chk++; if (match_count !== 16'd1) begin n_fail++; $display("FAIL post_clr_count: got %0d want 1", match_count); end
  endtask

  initial begin
    test_reset;
    test_default_nonoverlap;
    test_overlap;
    test_back_to_back;
    test_cfg_err;
    test_valid_gaps;
    test_en_drop;
    test_async_reset;
    test_saturate;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
